// File: rtl/jk_flip_flop.sv
// jk_flip_flop: bank of WIDTH edge-triggered JK bits (clk, rst_n async low, J/K commands in, Q/Qbar out)
module jk_flip_flop #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);
  logic [WIDTH-1:0] q_q, q_d;
  assign q_d = (J & ~q_q) | (~K & q_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VAL;
    else q_q <= q_d;
  end
  assign Q    = q_q;
  assign Qbar = ~q_q;
endmodule

// File: tb/tb_jk_flip_flop.sv
// tb_jk_flip_flop: self-checking bench for 1-bit and 4-bit JK flip-flop banks
module tb_jk_flip_flop;
  logic clk = 1'b0;
  logic rst_n;
  logic j1, k1, q1, qb1;
  logic [3:0] j4, k4, q4, qb4;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .J(j1), .K(k1), .Q(q1), .Qbar(qb1));
  jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) u_w4 (
    .clk(clk), .rst_n(rst_n), .J(j4), .K(k4), .Q(q4), .Qbar(qb4));

  typedef struct {
    logic j;
    logic k;
    logic q;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    if (j && k) return !q;
    if (j) return 1'b1;
    if (k) return 1'b0;
    return q;
  endfunction

  initial begin
    vec_t vecs[7];
    logic m1;
    logic [3:0] m4;
    vecs = '{'{0, 0, 0}, '{0, 1, 0}, '{1, 0, 1}, '{1, 1, 0}, '{1, 1, 1}, '{1, 1, 0}, '{1, 1, 1}};
    rst_n = 1'b0;
    j1 = 1'b0; k1 = 1'b0; j4 = '0; k4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q1", {3'b0, q1}, 4'b0000);
    chk("reset_qb1", {3'b0, qb1}, 4'b0001);
    chk("reset_q4", q4, 4'b1010);
    chk("reset_qb4", qb4, 4'b0101);
    @(negedge clk) rst_n = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      j1 = vecs[i].j; k1 = vecs[i].k;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_q", i), {3'b0, q1}, {3'b0, vecs[i].q});
      chk($sformatf("vec%0d_qb", i), {3'b0, qb1}, {3'b0, ~vecs[i].q});
    end
    chk("hold_w4", q4, 4'b1010);
    @(negedge clk);
    j1 = 1'b1; k1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", {3'b0, q1}, 4'b0000);
    chk("async_rst_qb", {3'b0, qb1}, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_q", {3'b0, q1}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_set", {3'b0, q1}, 4'b0001);
    @(negedge clk);
    j1 = 1'b0; k1 = 1'b1;
    @(posedge clk);
    #1;
    chk("sample_clear", {3'b0, q1}, 4'b0000);
    j1 = 1'b0; k1 = 1'b0;
    #1 j1 = 1'b1;
    #1 j1 = 1'b0;
    #1;
    chk("sample_mid_pulse", {3'b0, q1}, 4'b0000);
    @(posedge clk);
    #1;
    chk("sample_next_edge", {3'b0, q1}, 4'b0000);
    @(negedge clk);
    j1 = 1'b1; k1 = 1'b0;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("coincident_rst", {3'b0, q1}, 4'b0000);
    chk("coincident_rst_w4", q4, 4'b1010);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_coincident_set", {3'b0, q1}, 4'b0001);
    @(negedge clk);
    j4 = 4'b0011; k4 = 4'b0101;
    @(posedge clk);
    #1;
    chk("w4_mixed_q", q4, 4'b1011);
    chk("w4_mixed_qb", qb4, 4'b0100);
    m1 = q1;
    m4 = q4;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 19) != 0);
      j1 = 1'($urandom); k1 = 1'($urandom);
      j4 = 4'($urandom); k4 = 4'($urandom);
      #1;
      if (!rst_n) begin
        m1 = 1'b0;
        m4 = 4'b1010;
        chk("rand_async_q1", {3'b0, q1}, {3'b0, m1});
        chk("rand_async_q4", q4, m4);
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        m1 = jk_next(m1, j1, k1);
        for (int b = 0; b < 4; b++) m4[b] = jk_next(m4[b], j4[b], k4[b]);
      end
      chk("rand_q1", {3'b0, q1}, {3'b0, m1});
      chk("rand_qb1", {3'b0, qb1}, {3'b0, ~m1});
      chk("rand_q4", q4, m4);
      chk("rand_qb4", qb4, ~m4);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
